// File: rtl/rx_deframer.sv
// rx_deframer: hunts a fixed sync word in a decoded 1-bit AXI-Stream, then emits a fixed-length byte frame.
// Define RX_DEFRAMER_SYNC_TOL_EN to accept a sync word with up to MAX_BIT_ERR flipped bits.
module rx_deframer #(
    parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D,
    parameter int unsigned SYNC_LEN      = 32,
    parameter int unsigned PAYLOAD_BYTES = 16,
    parameter int unsigned MAX_BIT_ERR   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       sync_lock,
    output logic       sync_pulse
);

    typedef enum logic {
        HUNT,
        PAYLOAD
    } state_t;

    localparam logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];
    localparam logic [5:0]          FILL_MAX = 6'(SYNC_LEN);
    localparam logic [5:0]          FILL_MIN = 6'(SYNC_LEN - 1);
    localparam logic [7:0]          LAST_IDX = 8'(PAYLOAD_BYTES - 1);
`ifdef RX_DEFRAMER_SYNC_TOL_EN
    localparam int unsigned ERR_LIMIT = MAX_BIT_ERR;
`else
    // Exact match only; MAX_BIT_ERR has no effect in this build.
    localparam int unsigned ERR_LIMIT = 0 * MAX_BIT_ERR;
`endif

    state_t                state;
    // Only the newest SYNC_LEN-1 bits are kept: the incoming bit completes the candidate.
    logic [SYNC_LEN-2:0]   sr;
    logic [5:0]            fill;
    logic [2:0]            bit_cnt;
    logic [7:0]            byte_cnt;
    logic [6:0]            asm_q;

    logic [SYNC_LEN-1:0]   candidate;
    logic [SYNC_LEN-1:0]   mismatch;
    int unsigned           err_cnt;
    logic                  sync_hit;
    logic                  in_acc;
    logic                  out_acc;
    logic                  last_byte;

    assign in_ready  = (state == HUNT) || !out_valid || out_ready;
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign candidate = {sr, in_data};
    assign mismatch  = candidate ^ SYNC_PAT;
    assign last_byte = (byte_cnt == LAST_IDX);

    always_comb begin
        err_cnt = 0;
        for (int unsigned i = 0; i < SYNC_LEN; i++) begin
            err_cnt = err_cnt + {31'd0, mismatch[i]};
        end
    end

    assign sync_hit = (fill >= FILL_MIN) && (err_cnt <= ERR_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            sr         <= '0;
            fill       <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            asm_q      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            sync_lock  <= 1'b0;
            sync_pulse <= 1'b0;
        end else begin
            sync_pulse <= 1'b0;
            if (out_acc) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                HUNT: begin
                    if (in_acc) begin
                        sr <= candidate[SYNC_LEN-2:0];
                        if (fill != FILL_MAX) begin
                            fill <= fill + 6'd1;
                        end
                        if (sync_hit) begin
                            state      <= PAYLOAD;
                            bit_cnt    <= '0;
                            byte_cnt   <= '0;
                            sync_lock  <= 1'b1;
                            sync_pulse <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (in_acc) begin
                        asm_q   <= {asm_q[5:0], in_data};
                        bit_cnt <= bit_cnt + 3'd1;
                        // A completed byte overrides the accept-clear above, giving no bubble.
                        if (bit_cnt == 3'd7) begin
                            out_data  <= {asm_q, in_data};
                            out_valid <= 1'b1;
                            out_last  <= last_byte;
                            byte_cnt  <= byte_cnt + 8'd1;
                            if (last_byte) begin
                                state     <= HUNT;
                                sync_lock <= 1'b0;
                                sr        <= '0;
                                fill      <= '0;
                            end
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_deframer.sv
// Directed/randomized bench for rx_deframer against a bit-stream level reference model.
module tb_rx_deframer;

    localparam logic [31:0] SYNC = 32'h1ACFFC1D;
`ifdef RX_DEFRAMER_SYNC_TOL_EN
    localparam int TOL = 2;
`else
    localparam int TOL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_data = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       sync_lock;
    logic       sync_pulse;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // reference model state
    bit         m_hunt = 1'b1;
    logic       m_pend = 1'b0;
    logic       m_pulse = 1'b0;
    logic [7:0] m_byte = 8'h00;
    logic       m_last = 1'b0;
    logic       hunt_q[$];
    logic       pay_q[$];
    int         frame_bytes = 0;

    logic       bits_q[$];
    logic [8:0] got_q[$];
    logic [7:0] exp_q[$];
    int         pulse_cnt = 0;
    bit         seen_valid = 1'b0;
    bit         seen_lock = 1'b0;

    rx_deframer #(
        .SYNC_WORD    (SYNC),
        .SYNC_LEN     (32),
        .PAYLOAD_BYTES(16),
        .MAX_BIT_ERR  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sync_lock (sync_lock),
        .sync_pulse(sync_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hunt = 1'b1;
        m_pend = 1'b0;
        m_pulse = 1'b0;
        m_byte = 8'h00;
        m_last = 1'b0;
        hunt_q.delete();
        pay_q.delete();
        frame_bytes = 0;
    endtask

    // One accepted input bit applied to the spec-level model.
    task automatic model_bit(input logic b);
        logic [31:0] win;
        logic [7:0]  byt;
        if (m_hunt) begin
            hunt_q.push_back(b);
            if (hunt_q.size() > 32) void'(hunt_q.pop_front());
            if (hunt_q.size() == 32) begin
                win = '0;
                for (int i = 0; i < 32; i++) win = {win[30:0], hunt_q[i]};
                if ($countones(win ^ SYNC) <= TOL) begin
                    m_hunt = 1'b0;
                    m_pulse = 1'b1;
                    hunt_q.delete();
                    pay_q.delete();
                    frame_bytes = 0;
                end
            end
        end else begin
            pay_q.push_back(b);
            if (pay_q.size() == 8) begin
                byt = '0;
                for (int i = 0; i < 8; i++) byt = {byt[6:0], pay_q[i]};
                pay_q.delete();
                m_byte = byt;
                m_last = (frame_bytes == 15);
                m_pend = 1'b1;
                frame_bytes++;
                if (m_last) m_hunt = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic iv, input logic id, input logic ordy, output logic acc);
        logic exp_ir;
        in_valid = iv;
        in_data = id;
        out_ready = ordy;
        #1;
        exp_ir = m_hunt || !m_pend || ordy;
        check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, m_pend);
        if (m_pend) begin
            check("out_data", out_data, m_byte);
            check("out_last", out_last, m_last);
        end
        check("sync_lock", sync_lock, !m_hunt);
        check("sync_pulse", sync_pulse, m_pulse);
        acc = iv && in_ready;
        if (out_valid) seen_valid = 1'b1;
        if (sync_lock) seen_lock = 1'b1;
        if (sync_pulse) pulse_cnt++;
        if (out_valid && ordy) got_q.push_back({out_last, out_data});
        if (m_pend && ordy) m_pend = 1'b0;
        m_pulse = 1'b0;
        if (iv && exp_ir) model_bit(id);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sync_lock", sync_lock, 0);
        check("rst_sync_pulse", sync_pulse, 0);
        check("rst_in_ready", in_ready, 1);
        model_reset();
        bits_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic push_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) bits_q.push_back(w[i]);
    endtask

    // mode 0: continuous; mode 1: random in_valid gaps, out_ready high one cycle in three
    task automatic play(input int mode);
        logic acc;
        logic iv;
        logic ordy;
        int   tries;
        while (bits_q.size() > 0) begin
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 40) begin
                if (mode == 0) begin
                    iv = 1'b1;
                    ordy = 1'b1;
                end else begin
                    iv = ($urandom_range(0, 3) != 0);
                    ordy = ((cyc % 3) == 0);
                end
                cycle(iv, bits_q[0], ordy, acc);
                tries++;
            end
            if (!acc) check("in_accept_timeout", acc, 1);
            void'(bits_q.pop_front());
        end
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, acc);
        check("drained", out_valid, 0);
    endtask

    task automatic check_got(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check({tag, "_byte"}, got_q[i][7:0], exp_q[i]);
                check({tag, "_last"}, got_q[i][8], (i % 16) == 15);
            end
        end
    endtask

    initial begin
        logic acc;
        logic [7:0] rb;
        #2;
        do_reset();

        // 40 random bits: nothing locks, input never stalls
        seen_valid = 1'b0;
        seen_lock = 1'b0;
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, acc);
        check("s1_no_valid", seen_valid, 0);
        check("s1_no_lock", seen_lock, 0);

        // single frame, out_ready high
        got_q.delete();
        exp_q.delete();
        pulse_cnt = 0;
        push_word(SYNC, 32);
        for (int b = 0; b < 16; b++) begin
            push_word(32'(b), 8);
            exp_q.push_back(8'(b));
        end
        play(0);
        drain();
        check_got("s2");
        check("s2_pulses", pulse_cnt, 1);
        check("s2_lock_end", sync_lock, 0);

        // same frame with stalls and input gaps
        got_q.delete();
        pulse_cnt = 0;
        push_word(SYNC, 32);
        for (int b = 0; b < 16; b++) push_word(32'(b), 8);
        play(1);
        drain();
        check_got("s3");
        check("s3_pulses", pulse_cnt, 1);

        // two frames back to back
        got_q.delete();
        exp_q.delete();
        pulse_cnt = 0;
        push_word(SYNC, 32);
        for (int b = 0; b < 16; b++) begin
            push_word(32'(b), 8);
            exp_q.push_back(8'(b));
        end
        push_word(SYNC, 32);
        for (int b = 0; b < 16; b++) begin
            rb = 8'($urandom_range(0, 255));
            push_word({24'd0, rb}, 8);
            exp_q.push_back(rb);
        end
        play(0);
        drain();
        check_got("s4");
        check("s4_pulses", pulse_cnt, 2);

        // reset after 5 payload bytes, then a fresh frame
        push_word(SYNC, 32);
        for (int b = 0; b < 5; b++) push_word(32'($urandom_range(1, 255)), 8);
        play(0);
        check("s5_locked_midframe", sync_lock, 1);
        do_reset();
        got_q.delete();
        exp_q.delete();
        push_word(SYNC, 32);
        for (int b = 0; b < 16; b++) begin
            rb = 8'($urandom_range(0, 255));
            push_word({24'd0, rb}, 8);
            exp_q.push_back(rb);
        end
        play(0);
        drain();
        check_got("s5");

        // sync error tolerance
`ifdef RX_DEFRAMER_SYNC_TOL_EN
        do_reset();
        push_word(SYNC ^ 32'h0002_0008, 32);
        play(0);
        check("tol_2flip_lock", sync_lock, 1);
        do_reset();
        push_word(SYNC ^ 32'h0102_0008, 32);
        play(0);
        check("tol_3flip_nolock", sync_lock, 0);
`else
        do_reset();
        push_word(SYNC ^ 32'h0000_0100, 32);
        play(0);
        check("exact_1flip_nolock", sync_lock, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
